wb_trace_fifo: RTL and testbench

- Consumer of the MEM/WB pipeline register outputs: taps the writeback bundle (have_inst, pc, rf_we, wR, wD) every cycle.
- Buffers each retired instruction as one commit record, in a FIFO.
- Drains records to the off-core trace/difftest port over a valid/ready handshake.
- Raises a stall request toward the pipeline hazard unit before the FIFO fills.

---
 rtl/wb_trace_pkg.sv | 36 +++
 rtl/wb_trace_mem.sv | 33 +++
 rtl/wb_trace_fifo.sv | 124 ++++++++++++
 tb/tb_wb_trace_fifo.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/wb_trace_pkg.sv
// rtl/wb_trace_pkg.sv - shared widths and commit-record layout for the writeback trace FIFO
//
// Record layout, MSB to LSB: pc[69:38], we[37], wR[36:32], wD[31:0].
package wb_trace_pkg;

    localparam int TRACE_PC_W  = 32;
    localparam int TRACE_WR_W  = 5;
    localparam int TRACE_WD_W  = 32;
    localparam int TRACE_REC_W = TRACE_PC_W + 1 + TRACE_WR_W + TRACE_WD_W;
    localparam int DROP_CNT_W  = 16;

    // Packed member order fixes the bit offsets of the stored record.
    typedef struct packed {
        logic [TRACE_PC_W-1:0] pc;
        logic                  we;
        logic [TRACE_WR_W-1:0] wr;
        logic [TRACE_WD_W-1:0] wd;
    } trace_rec_t;

    // Writes to x0 never change architectural state, so their data is
    // canonicalised to zero to keep the trace comparable with a reference model.
    function automatic trace_rec_t pack_rec(
        input logic [TRACE_PC_W-1:0] pc,
        input logic                  we,
        input logic [TRACE_WR_W-1:0] wr,
        input logic [TRACE_WD_W-1:0] wd
    );
        trace_rec_t rec;
        rec.pc = pc;
        rec.we = we;
        rec.wr = wr;
        rec.wd = (we && (wr != '0)) ? wd : '0;
        return rec;
    endfunction

endpackage

// File: rtl/wb_trace_mem.sv
// rtl/wb_trace_mem.sv - record storage array, one synchronous write port, one asynchronous read port
//
// Ports:
//   i_clk    clock, rising edge
//   i_we     write enable
//   i_waddr  write slot index
//   i_wdata  record to store
//   i_raddr  read slot index
//   o_rdata  record at i_raddr (combinational)
module wb_trace_mem #(
    parameter int DEPTH = 8,
    parameter int W     = 70
) (
    input  logic                     i_clk,
    input  logic                     i_we,
    input  logic [$clog2(DEPTH)-1:0] i_waddr,
    input  logic [W-1:0]             i_wdata,
    input  logic [$clog2(DEPTH)-1:0] i_raddr,
    output logic [W-1:0]             o_rdata
);

    // Contents are deliberately not reset; the FIFO gates outputs by occupancy.
    logic [W-1:0] r_mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/wb_trace_fifo.sv
// rtl/wb_trace_fifo.sv - commit-record FIFO between the MEM/WB register and the trace port
//
// Ports:
//   clk, rst_n          clock (rising edge), synchronous active-low reset
//   wb_have_inst_i      retiring instruction this cycle (push)
//   wb_pc_i/rf_we_i/wR_i/wD_i  writeback bundle of the retiring instruction
//   trace_valid_o       head record available (first-word fall-through)
//   trace_ready_i       sink accepts head record
//   trace_pc_o/we_o/wR_o/wD_o  head record fields, zero while empty
//   stall_req_o         almost-full request toward the hazard unit
//   overflow_o          sticky, a record was dropped since reset
//   drop_cnt_o          saturating count of dropped records
//   count_o             current occupancy
module wb_trace_fifo
    import wb_trace_pkg::*;
#(
    parameter int DEPTH     = 8,
    parameter int AFULL_LVL = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    wb_have_inst_i,
    input  logic [TRACE_PC_W-1:0]   wb_pc_i,
    input  logic                    wb_rf_we_i,
    input  logic [TRACE_WR_W-1:0]   wb_wR_i,
    input  logic [TRACE_WD_W-1:0]   wb_wD_i,
    output logic                    trace_valid_o,
    input  logic                    trace_ready_i,
    output logic [TRACE_PC_W-1:0]   trace_pc_o,
    output logic                    trace_we_o,
    output logic [TRACE_WR_W-1:0]   trace_wR_o,
    output logic [TRACE_WD_W-1:0]   trace_wD_o,
    output logic                    stall_req_o,
    output logic                    overflow_o,
    output logic [DROP_CNT_W-1:0]   drop_cnt_o,
    output logic [$clog2(DEPTH):0]  count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] AFULL_C = CW'(AFULL_LVL);

    logic [AW-1:0]         r_wr_ptr;
    logic [AW-1:0]         r_rd_ptr;
    logic [CW-1:0]         r_count;
    logic                  r_overflow;
    logic [DROP_CNT_W-1:0] r_drop_cnt;

    logic                   w_valid;
    logic                   w_full;
    logic                   w_pop;
    logic                   w_wr_en;
    logic                   w_drop;
    logic [CW-1:0]          w_free;
    trace_rec_t             w_wr_rec;
    trace_rec_t             w_rd_rec;
    logic [TRACE_REC_W-1:0] w_rd_data;

    assign w_valid = (r_count != '0);
    assign w_full  = (r_count == DEPTH_C);
    assign w_pop   = w_valid & trace_ready_i;
    // When full, a push still lands if the head leaves in the same cycle.
    assign w_wr_en = wb_have_inst_i & (~w_full | w_pop);
    assign w_drop  = wb_have_inst_i & w_full & ~w_pop;

    assign w_wr_rec = pack_rec(wb_pc_i, wb_rf_we_i, wb_wR_i, wb_wD_i);

    wb_trace_mem #(
        .DEPTH (DEPTH),
        .W     (TRACE_REC_W)
    ) u_mem (
        .i_clk   (clk),
        .i_we    (w_wr_en),
        .i_waddr (r_wr_ptr),
        .i_wdata (w_wr_rec),
        .i_raddr (r_rd_ptr),
        .o_rdata (w_rd_data)
    );

    assign w_rd_rec = trace_rec_t'(w_rd_data);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
            r_drop_cnt <= '0;
        end else begin
            if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_wr_en, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
            if (w_drop) begin
                r_overflow <= 1'b1;
                if (r_drop_cnt != '1) begin
                    r_drop_cnt <= r_drop_cnt + DROP_CNT_W'(1);
                end
            end
        end
    end

    // Stale storage is hidden while empty so the sink never sees leftovers.
    assign trace_valid_o = w_valid;
    assign trace_pc_o    = w_valid ? w_rd_rec.pc : '0;
    assign trace_we_o    = w_valid & w_rd_rec.we;
    assign trace_wR_o    = w_valid ? w_rd_rec.wr : '0;
    assign trace_wD_o    = w_valid ? w_rd_rec.wd : '0;

    assign w_free      = DEPTH_C - r_count;
    assign stall_req_o = (w_free <= AFULL_C);
    assign overflow_o  = r_overflow;
    assign drop_cnt_o  = r_drop_cnt;
    assign count_o     = r_count;

endmodule

// File: tb/tb_wb_trace_fifo.sv
// tb/tb_wb_trace_fifo.sv - directed and random scoreboard bench for wb_trace_fifo
module tb_wb_trace_fifo;

    localparam int DEPTH     = 8;
    localparam int AFULL_LVL = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wb_have_inst_i;
    logic [31:0] wb_pc_i;
    logic        wb_rf_we_i;
    logic [4:0]  wb_wR_i;
    logic [31:0] wb_wD_i;
    logic        trace_valid_o;
    logic        trace_ready_i;
    logic [31:0] trace_pc_o;
    logic        trace_we_o;
    logic [4:0]  trace_wR_o;
    logic [31:0] trace_wD_o;
    logic        stall_req_o;
    logic        overflow_o;
    logic [15:0] drop_cnt_o;
    logic [$clog2(DEPTH):0] count_o;

    wb_trace_fifo #(
        .DEPTH     (DEPTH),
        .AFULL_LVL (AFULL_LVL)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .wb_have_inst_i (wb_have_inst_i),
        .wb_pc_i        (wb_pc_i),
        .wb_rf_we_i     (wb_rf_we_i),
        .wb_wR_i        (wb_wR_i),
        .wb_wD_i        (wb_wD_i),
        .trace_valid_o  (trace_valid_o),
        .trace_ready_i  (trace_ready_i),
        .trace_pc_o     (trace_pc_o),
        .trace_we_o     (trace_we_o),
        .trace_wR_o     (trace_wR_o),
        .trace_wD_o     (trace_wD_o),
        .stall_req_o    (stall_req_o),
        .overflow_o     (overflow_o),
        .drop_cnt_o     (drop_cnt_o),
        .count_o        (count_o)
    );

    always #5 clk = ~clk;

    logic [69:0] sb_q[$];
    int          n_assert = 0;
    int          n_fail   = 0;
    bit          m_ovf    = 1'b0;
    int          m_drop   = 0;

    task automatic check(input string tag, input logic [69:0] obs, input logic [69:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        int          n;
        logic [69:0] head;
        n    = sb_q.size();
        head = (n != 0) ? sb_q[0] : 70'd0;
        check("valid",    70'(trace_valid_o), 70'(n != 0));
        check("count",    70'(count_o),       70'(n));
        check("pc",       70'(trace_pc_o),    70'(head[69:38]));
        check("we",       70'(trace_we_o),    70'(head[37]));
        check("wR",       70'(trace_wR_o),    70'(head[36:32]));
        check("wD",       70'(trace_wD_o),    70'(head[31:0]));
        check("stall",    70'(stall_req_o),   70'((DEPTH - n) <= AFULL_LVL));
        check("overflow", 70'(overflow_o),    70'(m_ovf));
        check("drop_cnt", 70'(drop_cnt_o),    70'(m_drop));
    endtask

    // One clock: drive inputs, check current outputs against the model, then
    // advance the model across the rising edge.
    task automatic cycle(input bit push, input logic [31:0] pc, input bit we,
                         input logic [4:0] wr, input logic [31:0] wd, input bit ready);
        int          n;
        bit          pop;
        bit          accept;
        logic [31:0] wd_n;
        wb_have_inst_i = push;
        wb_pc_i        = pc;
        wb_rf_we_i     = we;
        wb_wR_i        = wr;
        wb_wD_i        = wd;
        trace_ready_i  = ready;
        #1;
        check_outputs();
        n      = sb_q.size();
        pop    = (n != 0) && ready;
        accept = push && ((n != DEPTH) || pop);
        wd_n   = (we && (wr != 5'd0)) ? wd : 32'd0;
        @(posedge clk);
        if (pop) void'(sb_q.pop_front());
        if (accept) sb_q.push_back({pc, we, wr, wd_n});
        else if (push) begin
            m_ovf = 1'b1;
            if (m_drop < 65535) m_drop++;
        end
        @(negedge clk);
    endtask

    task automatic idle(input bit ready);
        cycle(1'b0, 32'd0, 1'b0, 5'd0, 32'd0, ready);
    endtask

    task automatic do_reset();
        rst_n          = 1'b0;
        wb_have_inst_i = 1'b0;
        trace_ready_i  = 1'b0;
        @(posedge clk);
        sb_q.delete();
        m_ovf  = 1'b0;
        m_drop = 0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic drain();
        for (int k = 0; k < 4 * DEPTH && sb_q.size() != 0; k++) idle(1'b1);
        check("drain_empty", 70'(sb_q.size()), 70'd0);
    endtask

    logic [31:0] exp_pc;

    initial begin
        rst_n          = 1'b0;
        wb_have_inst_i = 1'b0;
        wb_pc_i        = '0;
        wb_rf_we_i     = 1'b0;
        wb_wR_i        = '0;
        wb_wD_i        = '0;
        trace_ready_i  = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Reset state
        check("rst_valid", 70'(trace_valid_o), 70'd0);
        check("rst_count", 70'(count_o),       70'd0);
        check("rst_stall", 70'(stall_req_o),   70'd0);
        check_outputs();

        // Single push, then pop
        cycle(1'b1, 32'h8000_0000, 1'b1, 5'd5, 32'h1234, 1'b0);
        check("t1_valid", 70'(trace_valid_o), 70'd1);
        check("t1_pc",    70'(trace_pc_o),    70'h8000_0000);
        check("t1_we",    70'(trace_we_o),    70'd1);
        check("t1_wR",    70'(trace_wR_o),    70'd5);
        check("t1_wD",    70'(trace_wD_o),    70'h1234);
        check("t1_count", 70'(count_o),       70'd1);
        idle(1'b1);
        check("t1_valid_after", 70'(trace_valid_o), 70'd0);
        check("t1_pc_after",    70'(trace_pc_o),    70'd0);
        check("t1_wD_after",    70'(trace_wD_o),    70'd0);

        // x0 canonicalisation
        cycle(1'b1, 32'h10, 1'b1, 5'd0, 32'hDEAD_BEEF, 1'b0);
        check("x0_wD", 70'(trace_wD_o), 70'd0);
        check("x0_we", 70'(trace_we_o), 70'd1);
        idle(1'b1);
        cycle(1'b1, 32'h14, 1'b0, 5'd3, 32'h55, 1'b0);
        check("nowe_wD", 70'(trace_wD_o), 70'd0);
        check("nowe_wR", 70'(trace_wR_o), 70'd3);
        idle(1'b1);
        idle(1'b0);

        // Fill with ready low
        for (int i = 0; i < DEPTH; i++) begin
            cycle(1'b1, 32'(i * 4), 1'b1, 5'd1, 32'(i + 100), 1'b0);
            if (i == 4) check("stall_at5", 70'(stall_req_o), 70'd0);
            if (i == 5) check("stall_at6", 70'(stall_req_o), 70'd1);
        end
        cycle(1'b1, 32'h20, 1'b1, 5'd1, 32'h99, 1'b0);
        check("ovf_set",   70'(overflow_o), 70'd1);
        check("drop_one",  70'(drop_cnt_o), 70'd1);
        check("full_cnt",  70'(count_o),    70'd8);

        // Full with simultaneous push and pop
        cycle(1'b1, 32'h100, 1'b1, 5'd2, 32'h100, 1'b1);
        check("pp_count", 70'(count_o),    70'd8);
        check("pp_drop",  70'(drop_cnt_o), 70'd1);
        for (int k = 0; k < DEPTH; k++) begin
            exp_pc = (k < DEPTH - 1) ? 32'((k + 1) * 4) : 32'h100;
            check("drain_order", 70'(trace_pc_o), 70'(exp_pc));
            idle(1'b1);
        end
        check("drained_valid", 70'(trace_valid_o), 70'd0);

        // Random wrap-around stress
        for (int c = 0; c < 1000; c++) begin
            cycle(1'($urandom_range(0, 1)), $urandom(), 1'($urandom_range(0, 1)),
                  5'($urandom_range(0, 31)), $urandom(), 1'($urandom_range(0, 1)));
        end
        drain();

        // Reset mid-operation
        for (int i = 0; i < 5; i++) cycle(1'b1, 32'(32'h200 + i * 4), 1'b1, 5'd7, 32'(i), 1'b0);
        check("pre_rst_count", 70'(count_o),    70'd5);
        check("pre_rst_ovf",   70'(overflow_o), 70'd1);
        do_reset();
        check("mid_rst_valid", 70'(trace_valid_o), 70'd0);
        check("mid_rst_count", 70'(count_o),       70'd0);
        check("mid_rst_ovf",   70'(overflow_o),    70'd0);
        check("mid_rst_drop",  70'(drop_cnt_o),    70'd0);
        check("mid_rst_stall", 70'(stall_req_o),   70'd0);
        cycle(1'b1, 32'h300, 1'b1, 5'd9, 32'hABCD, 1'b0);
        check("post_rst_pc", 70'(trace_pc_o), 70'h300);
        check("post_rst_wD", 70'(trace_wD_o), 70'hABCD);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
